// File: rtl/sram_axi_bridge_n.sv
// Merges NUM_PORTS SRAM-like ports onto one AXI3 master: round-robin, one capture per cycle, addr_ok/data_ok combinational.
// Read >= 2 cycles, write >= 2 cycles; ports stall (addr_ok low) on full AR slot, read limit, RAW hazard or busy write.
module sram_axi_bridge_n #(
    parameter int NUM_PORTS  = 2,
    parameter int MAX_RD_OUT = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_PORTS-1:0]    req,
    input  logic [NUM_PORTS-1:0]    wr,
    input  logic [2*NUM_PORTS-1:0]  size,
    input  logic [4*NUM_PORTS-1:0]  sram_wstrb,
    input  logic [32*NUM_PORTS-1:0] addr,
    input  logic [32*NUM_PORTS-1:0] sram_wdata,
    output logic [NUM_PORTS-1:0]    addr_ok,
    output logic [NUM_PORTS-1:0]    data_ok,
    output logic [31:0]             rdata_o,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int CW = $clog2(MAX_RD_OUT + 1);
    localparam logic [CW-1:0] RD_MAX = CW'(MAX_RD_OUT);

    logic [CW-1:0]        rd_cnt [NUM_PORTS];
    logic [3:0]           rr;
    logic                 w_busy;
    logic [3:0]           wr_id;

    logic                 ar_free;
    logic                 b_hs;
    logic                 cap;
    logic                 gnt_vld;
    logic                 gnt_wr;
    logic [3:0]           gnt_idx;
    logic [NUM_PORTS-1:0] rd_cand;
    logic [NUM_PORTS-1:0] wr_cand;
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] gnt_oh;
    logic [NUM_PORTS-1:0] rd_inc;
    logic [NUM_PORTS-1:0] rd_dec;
    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic [1:0]           sel_size;
    logic [3:0]           sel_wstrb;
    logic                 unused_resp;

    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wlast   = 1'b1;
    assign rready  = 1'b1;
    assign awid    = wr_id;
    assign wid     = wr_id;

    assign unused_resp = ^{rresp, rlast, bresp};

    // A read beat for the writing ID takes priority; its B waits one cycle.
    assign bready  = ~(rvalid && (rid == wr_id));
    assign b_hs    = bvalid & bready;
    assign ar_free = ~arvalid | arready;
    assign rdata_o = (aresetn && rvalid) ? rdata : 32'd0;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_cand[i] = req[i] & ~wr[i] & ar_free & (rd_cnt[i] < RD_MAX)
                       & ~(w_busy & (addr[32*i+2 +: 30] == awaddr[31:2]));
            wr_cand[i] = req[i] & wr[i] & ~w_busy;
        end
        cand = rd_cand | wr_cand;
    end

    // Scan positions rr, rr+1, ... (mod NUM_PORTS); first candidate wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 4'd0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!gnt_vld && cand[j] &&
                    ((int'(rr) + k == j) || (int'(rr) + k == j + NUM_PORTS))) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 4'(j);
                end
            end
        end
    end

    always_comb begin
        cap       = gnt_vld & aresetn;
        gnt_oh    = '0;
        gnt_wr    = 1'b0;
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        sel_size  = 2'd0;
        sel_wstrb = 4'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_idx == 4'(i)) begin
                gnt_oh[i] = cap;
                gnt_wr    = wr[i];
                sel_addr  = addr[32*i +: 32];
                sel_wdata = sram_wdata[32*i +: 32];
                sel_size  = size[2*i +: 2];
                sel_wstrb = sram_wstrb[4*i +: 4];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_inc[i]  = gnt_oh[i] & ~gnt_wr;
            rd_dec[i]  = aresetn & rvalid & (rid == 4'(i)) & (rd_cnt[i] != '0);
            data_ok[i] = aresetn & ((rvalid & (rid == 4'(i))) | (b_hs & (bid == 4'(i))));
        end
        addr_ok = gnt_oh;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arvalid <= 1'b0;
            arid    <= 4'd0;
            araddr  <= 32'd0;
            arsize  <= 3'd0;
            awvalid <= 1'b0;
            awaddr  <= 32'd0;
            awsize  <= 3'd0;
            wvalid  <= 1'b0;
            wdata   <= 32'd0;
            wstrb   <= 4'd0;
            wr_id   <= 4'd0;
            w_busy  <= 1'b0;
            rr      <= 4'd0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_cnt[i] <= '0;
            end
        end else begin
            if (arvalid && arready) arvalid <= 1'b0;
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if (b_hs)               w_busy  <= 1'b0;

            if (cap) begin
                rr <= (gnt_idx == 4'(NUM_PORTS - 1)) ? 4'd0 : gnt_idx + 4'd1;
                if (gnt_wr) begin
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                    w_busy  <= 1'b1;
                    wr_id   <= gnt_idx;
                    awaddr  <= sel_addr;
                    awsize  <= {1'b0, sel_size};
                    wdata   <= sel_wdata;
                    wstrb   <= sel_wstrb;
                end else begin
                    arvalid <= 1'b1;
                    arid    <= gnt_idx;
                    araddr  <= sel_addr;
                    arsize  <= {1'b0, sel_size};
                end
            end

            for (int i = 0; i < NUM_PORTS; i++) begin
                if (rd_inc[i] && !rd_dec[i])
                    rd_cnt[i] <= rd_cnt[i] + CW'(1);
                else if (!rd_inc[i] && rd_dec[i])
                    rd_cnt[i] <= rd_cnt[i] - CW'(1);
            end
        end
    end

endmodule
